// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT widths, state codes, Q2.8 constants and saturation helper
package fft_pkg;
  localparam int DW    = 19;
  localparam int OW    = DW + 1;
  localparam int TW    = 10;
  localparam int DEPTH = 16;
  localparam int PW    = 31;

  localparam logic signed [TW-1:0] ONE     = 10'sd256;
  localparam logic signed [PW-1:0] RND     = 31'sd128;
  localparam logic signed [OW-1:0] SAT_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] SAT_MIN = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FIRST   = 2'b01,
    ST_SECOND  = 2'b10,
    ST_WAITING = 2'b11
  } state_e;

  // Drop the Q2.8 fraction (already rounded by the caller) and clamp to OW bits.
  function automatic logic signed [OW-1:0] q28_sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] s;
    s = v >>> 8;
    if (s > PW'(SAT_MAX))      q28_sat = SAT_MAX;
    else if (s < PW'(SAT_MIN)) q28_sat = SAT_MIN;
    else                       q28_sat = s[OW-1:0];
  endfunction
endpackage

// File: rtl/cmul_q28.sv
// rtl/cmul_q28.sv - combinational complex multiply by a Q2.8 twiddle with round half up and saturate
module cmul_q28
  import fft_pkg::*;
(
  input  logic signed [OW-1:0] i_ar,
  input  logic signed [OW-1:0] i_ai,
  input  logic signed [TW-1:0] i_wr,
  input  logic signed [TW-1:0] i_wi,
  output logic signed [OW-1:0] o_pr,
  output logic signed [OW-1:0] o_pi
);
  logic signed [PW-1:0] w_ar, w_ai, w_wr, w_wi;
  logic signed [PW-1:0] w_pr, w_pi;

  assign w_ar = PW'(i_ar);
  assign w_ai = PW'(i_ai);
  assign w_wr = PW'(i_wr);
  assign w_wi = PW'(i_wi);

  assign w_pr = w_ar * w_wr - w_ai * w_wi;
  assign w_pi = w_ar * w_wi + w_ai * w_wr;

  assign o_pr = q28_sat(w_pr + RND);
  assign o_pi = q28_sat(w_pi + RND);
endmodule

// File: rtl/sdf_bf16_stage.sv
// rtl/sdf_bf16_stage.sv - stage-1 radix-2 SDF butterfly with 16-deep feedback delay line and twiddle multiply
module sdf_bf16_stage
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           state,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  input  logic signed [TW-1:0] WN_r,
  input  logic signed [TW-1:0] WN_i,
  output logic signed [OW-1:0] data_out_r,
  output logic signed [OW-1:0] data_out_i,
  output logic                 valid_o,
  output logic                 last_o
);
  state_e               w_state;
  logic signed [OW-1:0] r_dl_r [DEPTH];
  logic signed [OW-1:0] r_dl_i [DEPTH];
  logic [4:0]           r_idx;
  logic signed [OW-1:0] w_xr, w_xi, w_hr, w_hi;
  logic signed [OW-1:0] w_push_r, w_push_i;
  logic signed [OW-1:0] w_cm_r, w_cm_i;

  assign w_state = state_e'(state);
  assign w_xr    = OW'(data_in_r);
  assign w_xi    = OW'(data_in_i);
  assign w_hr    = r_dl_r[0];
  assign w_hi    = r_dl_i[0];

  cmul_q28 u_cmul (
    .i_ar (w_hr),
    .i_ai (w_hi),
    .i_wr (WN_r),
    .i_wi (WN_i),
    .o_pr (w_cm_r),
    .o_pi (w_cm_i)
  );

  // FIRST feeds the difference back; every other shifting state refills with the new sample.
  always_comb begin
    w_push_r = w_xr;
    w_push_i = w_xi;
    if (w_state == ST_FIRST) begin
      w_push_r = w_hr - w_xr;
      w_push_i = w_hi - w_xi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_dl_r[k] <= '0;
        r_dl_i[k] <= '0;
      end
    end else if (w_state != ST_IDLE) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        r_dl_r[k] <= r_dl_r[k+1];
        r_dl_i[k] <= r_dl_i[k+1];
      end
      r_dl_r[DEPTH-1] <= w_push_r;
      r_dl_i[DEPTH-1] <= w_push_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= '0;
      data_out_i <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      r_idx      <= '0;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      case (w_state)
        ST_FIRST: begin
          data_out_r <= w_hr + w_xr;
          data_out_i <= w_hi + w_xi;
          valid_o    <= 1'b1;
          r_idx      <= r_idx + 5'd1;
        end
        ST_SECOND: begin
          data_out_r <= w_cm_r;
          data_out_i <= w_cm_i;
          valid_o    <= 1'b1;
          last_o     <= (r_idx == 5'd31);
          r_idx      <= r_idx + 5'd1;
        end
        default: r_idx <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_sdf_bf16_stage.sv
// tb/tb_sdf_bf16_stage.sv - directed self-checking bench for sdf_bf16_stage
module tb_sdf_bf16_stage;
  localparam logic [1:0] S_IDLE = 2'b00, S_FIRST = 2'b01, S_SECOND = 2'b10, S_WAIT = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         state;
  logic signed [18:0] xr, xi;
  logic signed [9:0]  wr, wi;
  logic signed [19:0] dor, doi;
  logic               vo, lo;
  int                 checks = 0;
  int                 errors = 0;

  sdf_bf16_stage dut (
    .clk        (clk),
    .rst        (rst),
    .state      (state),
    .data_in_r  (xr),
    .data_in_i  (xi),
    .WN_r       (wr),
    .WN_i       (wi),
    .data_out_r (dor),
    .data_out_i (doi),
    .valid_o    (vo),
    .last_o     (lo)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] st, input int ar, input int ai, input int br, input int bi);
    state = st;
    xr = 19'(ar);
    xi = 19'(ai);
    wr = 10'(br);
    wi = 10'(bi);
    @(posedge clk);
    #1;
  endtask

  // Ramp frame x[n]=n+1; optional 5-cycle IDLE inserted before WAITING sample idle_at.
  task automatic test_ramp(input int w_r, input int w_i, input int er, input int ei,
                           input bit idle_after, input int idle_at, input int hr, input int hi);
    int nvalid = 0;
    logic signed [19:0] exp_r;
    for (int n = 0; n < 16; n++) begin
      if (n == idle_at) begin
        for (int k = 0; k < 5; k++) begin
          drive(S_IDLE, 777, -555, 99, -99);
          checks++;
          if (vo !== 1'b0 || lo !== 1'b0 || dor !== 20'(hr) || doi !== 20'(hi)) begin
            errors++;
            $display("FAIL idle_hold k=%0d got %0d/%0d v%0b l%0b want %0d/%0d v0 l0", k, dor, doi, vo, lo, hr, hi);
          end
          nvalid += int'(vo);
        end
      end
      drive(S_WAIT, n + 1, 0, 33, -44);
      checks++;
      if (vo !== 1'b0 || lo !== 1'b0) begin
        errors++;
        $display("FAIL wait_valid n=%0d got v%0b l%0b want v0 l0", n, vo, lo);
      end
      nvalid += int'(vo);
    end
    for (int n = 0; n < 16; n++) begin
      drive(S_FIRST, 17 + n, 0, 5, -3);
      exp_r = 20'(18 + 2 * n);
      checks++;
      if (dor !== exp_r || doi !== 20'sd0 || vo !== 1'b1 || lo !== 1'b0) begin
        errors++;
        $display("FAIL first_out n=%0d got %0d/%0d v%0b l%0b want %0d/0 v1 l0", n, dor, doi, vo, lo, exp_r);
      end
      nvalid += int'(vo);
    end
    for (int n = 0; n < 16; n++) begin
      drive(S_SECOND, 100 + n, 7, w_r, w_i);
      checks++;
      if (dor !== 20'(er) || doi !== 20'(ei) || vo !== 1'b1 || lo !== (n == 15)) begin
        errors++;
        $display("FAIL second_out n=%0d got %0d/%0d v%0b l%0b want %0d/%0d v1 l%0b", n, dor, doi, vo, lo, er, ei, n == 15);
      end
      nvalid += int'(vo);
    end
    if (idle_after) begin
      drive(S_IDLE, 0, 0, 0, 0);
      checks++;
      if (vo !== 1'b0 || lo !== 1'b0) begin
        errors++;
        $display("FAIL trail_idle got v%0b l%0b want v0 l0", vo, lo);
      end
      nvalid += int'(vo);
    end
    checks++;
    if (nvalid != 32) begin
      errors++;
      $display("FAIL valid_count got %0d want 32", nvalid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    state = S_IDLE;
    xr = '0; xi = '0; wr = '0; wi = '0;
    #1;
    checks++;
    if (dor !== 20'sd0 || doi !== 20'sd0 || vo !== 1'b0 || lo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d v%0b l%0b want 0/0 v0 l0", dor, doi, vo, lo);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp_unity();
    test_ramp(256, 0, -16, 0, 1'b1, -1, 0, 0);
  endtask

  task automatic test_ramp_minus_j();
    test_ramp(0, -256, 0, 16, 1'b1, -1, 0, 0);
  endtask

  task automatic test_idle_hold();
    test_ramp(256, 0, -16, 0, 1'b1, 8, 0, 16);
  endtask

  task automatic test_back_to_back();
    test_ramp(256, 0, -16, 0, 1'b0, -1, 0, 0);
    test_ramp(0, -256, 0, 16, 1'b1, -1, 0, 0);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 16; n++) drive(S_WAIT, -262144, -262144, 0, 0);
    for (int n = 0; n < 16; n++) begin
      drive(S_FIRST, 262143, 262143, 0, 0);
      checks++;
      if (dor !== -20'sd1 || doi !== -20'sd1 || vo !== 1'b1) begin
        errors++;
        $display("FAIL sat_first n=%0d got %0d/%0d v%0b want -1/-1 v1", n, dor, doi, vo);
      end
    end
    for (int n = 0; n < 16; n++) begin
      drive(S_SECOND, 0, 0, 181, 181);
      checks++;
      if (dor !== 20'sd0 || doi !== -20'sd524288 || lo !== (n == 15)) begin
        errors++;
        $display("FAIL sat_second n=%0d got %0d/%0d l%0b want 0/-524288 l%0b", n, dor, doi, lo, n == 15);
      end
    end
    drive(S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_rounding();
    for (int n = 0; n < 16; n++) drive(S_WAIT, 1, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      drive(S_FIRST, 0, 0, 0, 0);
      checks++;
      if (dor !== 20'sd1 || doi !== 20'sd0) begin
        errors++;
        $display("FAIL round_first n=%0d got %0d/%0d want 1/0", n, dor, doi);
      end
    end
    for (int n = 0; n < 16; n++) begin
      drive(S_SECOND, 0, 0, (n % 2 == 0) ? 128 : 127, 0);
      checks++;
      if (dor !== ((n % 2 == 0) ? 20'sd1 : 20'sd0) || doi !== 20'sd0) begin
        errors++;
        $display("FAIL round_second n=%0d got %0d/%0d want %0d/0", n, dor, doi, (n % 2 == 0) ? 1 : 0);
      end
    end
    drive(S_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_reset_midframe();
    for (int n = 0; n < 16; n++) drive(S_WAIT, n + 1, 0, 0, 0);
    for (int n = 0; n < 7; n++) drive(S_FIRST, 17 + n, 0, 0, 0);
    state = S_FIRST;
    xr = 19'sd24;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dor !== 20'sd0 || doi !== 20'sd0 || vo !== 1'b0 || lo !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got %0d/%0d v%0b l%0b want 0/0 v0 l0", dor, doi, vo, lo);
    end
    state = S_IDLE;
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_ramp(256, 0, -16, 0, 1'b1, -1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ramp_unity();
    test_ramp_minus_j();
    test_idle_hold();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
